// File: rtl/ram64_arb_pkg.sv
// Shared types and constants for the two-port 64x16 RAM arbiter.
// Optional stall counters in the top are enabled with RAM64_ARB_STATS_EN.
package ram64_arb_pkg;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 16;
    localparam int CNT_W    = 4;

    localparam int PORT_CPU = 0;
    localparam int PORT_LDR = 1;

    // One requester's access fields, packed in the order they drive the RAM.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ram_req_t;

    function automatic logic [CNT_W-1:0] burst_next(input logic [CNT_W-1:0] cnt,
                                                    input logic [CNT_W-1:0] max_cnt);
        return (cnt < max_cnt) ? cnt + 1'b1 : max_cnt;
    endfunction

endpackage

// File: rtl/ram64_arb_sched.sv
// Round-robin grant scheduler with a bounded burst allowance.
// Holds the last-granted port and its consecutive-grant count.
module ram64_arb_sched
    import ram64_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    logic             last_q;
    logic             last_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             winner;

    // Reset leaves last=1 with the allowance spent, so the first tie goes to port 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
            cnt_q  <= MAX_CNT;
        end else begin
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        cnt_d  = cnt_q;
        winner = 1'b0;

        if (!reset) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    if (cnt_q < MAX_CNT) gnt = last_q ? 2'b10 : 2'b01;
                    else                 gnt = last_q ? 2'b01 : 2'b10;
                end
                default: gnt = 2'b00;
            endcase
        end

        winner = gnt[1];
        // An idle cycle spends the allowance, breaking any burst in progress.
        if (gnt == 2'b00) begin
            cnt_d = MAX_CNT;
        end else if (winner == last_q) begin
            cnt_d = burst_next(cnt_q, MAX_CNT);
        end else begin
            last_d = winner;
            cnt_d  = CNT_W'(1);
        end
    end

endmodule

// File: rtl/ram64_arbiter.sv
// Two-port arbiter in front of the 64x16 RAM: CPU on port 0, loader on port 1.
// Define RAM64_ARB_STATS_EN to add the stall0/stall1 wait-cycle counters.
module ram64_arbiter
    import ram64_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
`ifdef RAM64_ARB_STATS_EN
    output logic [15:0]       stall0,
    output logic [15:0]       stall1,
`endif
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);

    // Handshake: a port's access happens in the cycle its gnt is high; a
    // waiting requester holds req (fields may change) until granted.
    ram_req_t   port_req [2];
    ram_req_t   sel;
    logic [1:0] gnt;

    assign port_req[PORT_CPU] = {we0, addr0, wdata0};
    assign port_req[PORT_LDR] = {we1, addr1, wdata1};

    ram64_arb_sched #(
        .MAX_BURST (MAX_BURST)
    ) u_sched (
        .clk   (clk),
        .reset (reset),
        .req   ({req1, req0}),
        .gnt   (gnt)
    );

    assign gnt0 = gnt[PORT_CPU];
    assign gnt1 = gnt[PORT_LDR];

    // With no grant the RAM sees all-zero fields, so ram_load stays low.
    always_comb begin
        sel = '0;
        if (gnt0)      sel = port_req[PORT_CPU];
        else if (gnt1) sel = port_req[PORT_LDR];
    end

    assign ram_address = sel.addr;
    assign ram_in      = sel.wdata;
    assign ram_load    = sel.we;

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 && !we0) rdata0 <= ram_out;
            if (gnt1 && !we1) rdata1 <= ram_out;
        end
    end

`ifdef RAM64_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall0 <= '0;
            stall1 <= '0;
        end else begin
            if (req0 && !gnt0 && stall0 != 16'hFFFF) stall0 <= stall0 + 16'd1;
            if (req1 && !gnt1 && stall1 != 16'hFFFF) stall1 <= stall1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram64_arbiter.sv
// Directed bench for ram64_arbiter with a behavioural 64x16 RAM behind it.
// Stall-counter checks are included when RAM64_ARB_STATS_EN is defined.
module tb_ram64_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [5:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic [5:0]  ram_address;
    logic [15:0] ram_in, ram_out;
    logic        ram_load;
`ifdef RAM64_ARB_STATS_EN
    logic [15:0] stall0, stall1;
`endif

    logic [15:0] mem [64];
    logic [1:0]  exp_q [$];
    int          n_checks;
    int          n_fail;

    ram64_arbiter #(.MAX_BURST(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .we0         (we0),
        .addr0       (addr0),
        .wdata0      (wdata0),
        .req1        (req1),
        .we1         (we1),
        .addr1       (addr1),
        .wdata1      (wdata1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .rvalid0     (rvalid0),
        .rvalid1     (rvalid1),
        .rdata0      (rdata0),
        .rdata1      (rdata1),
`ifdef RAM64_ARB_STATS_EN
        .stall0      (stall0),
        .stall1      (stall1),
`endif
        .ram_address (ram_address),
        .ram_in      (ram_in),
        .ram_load    (ram_load),
        .ram_out     (ram_out)
    );

    // Clock and reset-time RAM contents
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    end

    assign ram_out = mem[ram_address];
    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [5:0] a0, input logic [15:0] d0,
                         input logic r1, input logic w1, input logic [5:0] a1, input logic [15:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] exp_g;
        logic [1:0] prev_g;
        n_checks = 0;
        n_fail   = 0;

        // Reset held with both ports requesting writes: nothing may be granted.
        reset = 1'b1;
        drive(1'b1, 1'b1, 6'd5, 16'h1111, 1'b1, 1'b1, 6'd6, 16'h2222);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            check("rst_gnt", {gnt1, gnt0}, 2'b00);
            check("rst_load", ram_load, 1'b0);
            check("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
            check("rst_rdata0", rdata0, 16'h0000);
            check("rst_rdata1", rdata1, 16'h0000);
        end

        // Continuous contention from reset: 4 grants each way, port 0 first.
        exp_q = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        next_cycle();
        reset = 1'b0;
        drive(1'b1, 1'b0, 6'd5, 16'h1111, 1'b1, 1'b0, 6'd6, 16'h2222);
        prev_g = 2'b00;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) next_cycle();
            #1;
            exp_g = exp_q.pop_front();
            check($sformatf("burst_gnt%0d", k), {gnt1, gnt0}, exp_g);
            check($sformatf("burst_rvalid%0d", k), {rvalid1, rvalid0}, prev_g);
            check($sformatf("burst_load%0d", k), ram_load, 1'b0);
            prev_g = exp_g;
        end

        // Idle cycle: RAM fields forced to zero.
        next_cycle();
        drive(1'b0, 1'b1, 6'd9, 16'h5555, 1'b0, 1'b1, 6'd10, 16'hAAAA);
        #1;
        check("idle_gnt", {gnt1, gnt0}, 2'b00);
        check("idle_addr", ram_address, 6'd0);
        check("idle_in", ram_in, 16'h0000);
        check("idle_load", ram_load, 1'b0);
        check("idle_rvalid0", rvalid0, 1'b1);

        // Port 1 writes BEEF to 37, then reads it back.
        next_cycle();
        drive(1'b0, 1'b0, 6'd0, 16'h0000, 1'b1, 1'b1, 6'd37, 16'hBEEF);
        #1;
        check("p1_wr_gnt", {gnt1, gnt0}, 2'b10);
        check("p1_wr_addr", ram_address, 6'd37);
        check("p1_wr_in", ram_in, 16'hBEEF);
        check("p1_wr_load", ram_load, 1'b1);
        next_cycle();
        we1 = 1'b0;
        wdata1 = 16'h0000;
        #1;
        check("p1_rd_gnt", {gnt1, gnt0}, 2'b10);
        check("p1_rd_load", ram_load, 1'b0);
        check("p1_rd_addr", ram_address, 6'd37);
        check("p1_wr_no_rvalid", rvalid1, 1'b0);
        next_cycle();
        req1 = 1'b0;
        #1;
        check("p1_rvalid", rvalid1, 1'b1);
        check("p1_rdata", rdata1, 16'hBEEF);
        check("p1_rvalid0_quiet", rvalid0, 1'b0);
        next_cycle();
        #1;
        check("p1_rvalid_pulse", rvalid1, 1'b0);
        check("p1_rdata_hold", rdata1, 16'hBEEF);

        // Port 0 writes then reads address 0; two grants then an idle cycle.
        next_cycle();
        drive(1'b1, 1'b1, 6'd0, 16'h1234, 1'b0, 1'b0, 6'd0, 16'h0000);
        #1;
        check("p0_wr_gnt", {gnt1, gnt0}, 2'b01);
        check("p0_wr_in", ram_in, 16'h1234);
        check("p0_wr_load", ram_load, 1'b1);
        next_cycle();
        we0 = 1'b0;
        #1;
        check("p0_rd_gnt", {gnt1, gnt0}, 2'b01);
        next_cycle();
        req0 = 1'b0;
        #1;
        check("p0_rvalid", rvalid0, 1'b1);
        check("p0_rdata", rdata0, 16'h1234);
        check("p0_rvalid1_quiet", rvalid1, 1'b0);

        // After the idle cycle a tie goes to port 1, starting its burst.
        next_cycle();
        drive(1'b1, 1'b0, 6'd0, 16'h0000, 1'b1, 1'b0, 6'd37, 16'h0000);
        #1;
        check("idle_break_gnt", {gnt1, gnt0}, 2'b10);
        next_cycle();
        #1;
        check("p1_burst2_gnt", {gnt1, gnt0}, 2'b10);
        check("p1_burst2_rvalid", rvalid1, 1'b1);

        // Reset in the third port-1 burst cycle, with a read returning.
        next_cycle();
        reset = 1'b1;
        #1;
        check("midrst_gnt", {gnt1, gnt0}, 2'b00);
        check("midrst_load", ram_load, 1'b0);
        check("midrst_rvalid_pre", rvalid1, 1'b1);
        check("midrst_rdata_pre", rdata1, 16'hBEEF);
        next_cycle();
        reset = 1'b0;
        #1;
        check("midrst_rvalid", rvalid1, 1'b0);
        check("midrst_rdata1", rdata1, 16'h0000);
        check("midrst_rdata0", rdata0, 16'h0000);
        check("midrst_tie_gnt", {gnt1, gnt0}, 2'b01);

`ifdef RAM64_ARB_STATS_EN
        // From reset, port 0 wins four ties while port 1 waits.
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        drive(1'b1, 1'b0, 6'd1, 16'h0000, 1'b1, 1'b0, 6'd2, 16'h0000);
        #1;
        check("stats_rst0", stall0, 16'd0);
        check("stats_rst1", stall1, 16'd0);
        for (int k = 0; k < 3; k++) next_cycle();
        next_cycle();
        req0 = 1'b0;
        req1 = 1'b0;
        #1;
        check("stats_stall1", stall1, 16'd4);
        check("stats_stall0", stall0, 16'd0);
`endif

        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
